control_unit: RTL
=================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock.
REQ-002 SHALL have port clr, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port opcode, input, 5 bits: instruction opcode decoded by the datapath from IR[31:27].
REQ-004 SHALL have port CON_out, input, 1 bit: branch condition flag from the datapath.
REQ-005 SHALL have port gsel, output, 3 bits: {Gra,Grb,Grc}, at most one bit set.
REQ-006 SHALL have ports R_enable, Rout, BAout, output, 1 bit each: register-field write, register-field read, and base-address read.
REQ-007 SHALL have port bus_src, output, 8 bits, one-hot or zero: {Cout,InPortout,MDRout,PCout,ZLowout,ZHighout,LOout,HIout}.
REQ-008 SHALL have port ld_en, output, 11 bits: {enableOutPort,enableInPort,enableCON,enableLO,enableHI,enableZ,enableY,enablePC,enableIR,enableMDR,enableMAR}.
REQ-009 SHALL have ports RAM_read, RAM_write, IncPC, output, 1 bit each.
REQ-010 SHALL have port MDR_read, output, 3 bits: 3'b000 selects the bus, 3'b001 selects RAM.
REQ-011 SHALL have port run, output, 1 bit: high in every state except HALT.

Function
REQ-012 SHALL be a Moore FSM: all outputs are decoded from the registered state, which is updated on the rising edge of clk.
REQ-013 SHALL use the states T0, T1, T2 (fetch), E0–E4 (execute), and HALT.
REQ-014 SHALL perform fetch as follows:
- T0: PCout, MARin, IncPC, Zin.
- T1: ZLowout, PCin, RAM_read, MDR_read=001, MDRin.
- T2: MDRout, IRin.
REQ-015 SHALL sample opcode in E0; the transition out of T2 is always to E0.
REQ-016 SHALL sequence ALU reg-reg instructions (add, sub, and, or, shr, shl, ror, rol; opcodes 00011–01010) as:
- E0: Grb, Rout, Yin.
- E1: Grc, Rout, Zin.
- E2: ZLowout, Gra, R_enable.
- Then T0.
REQ-017 SHALL sequence addi, andi, ori (01011–01101) like REQ-016, with E1 using Cout in place of Grc/Rout.
REQ-018 SHALL sequence neg and not (10000, 10001) as:
- E0: Grb, Rout, Zin.
- E1: ZLowout, Gra, R_enable.
REQ-019 SHALL sequence ld (00000) as:
- E0: Grb, BAout, Yin.
- E1: Cout, Zin.
- E2: ZLowout, MARin.
- E3: RAM_read, MDR_read=001, MDRin.
- E4: MDRout, Gra, R_enable.
REQ-020 SHALL sequence ldi (00001) as ld E0–E1, followed by E2: ZLowout, Gra, R_enable.
REQ-021 SHALL sequence st (00010) as ld E0–E2, then:
- E3: Gra, Rout, MDR_read=000, MDRin.
- E4: RAM_write.
REQ-022 SHALL sequence br (10010) as:
- E0: Gra, Rout, CONin.
- E1: PCout, Yin.
- E2: Cout, Zin.
- E3: ZLowout, PCin only if CON_out=1; otherwise E3 asserts nothing.
REQ-023 SHALL sequence jr (10011) as E0: Gra, Rout, PCin.
REQ-024 SHALL sequence jal (10100) as:
- E0: PCout, R_enable with R15 selected via Grb convention.
- E1: Gra, Rout, PCin.
REQ-025 SHALL execute in, out, mfhi, mflo (10101–11000) in a single E0 step:
- in: InPortout, Gra, R_enable.
- out: Gra, Rout, OutPortin.
- mfhi: HIout, Gra, R_enable.
- mflo: LOout, Gra, R_enable.
REQ-026 SHALL treat nop (11001) and any undefined opcode as E0 with all outputs deasserted, then T0.
REQ-027 SHALL, on halt (11010), enter HALT from E0 and remain there, with all outputs zero and run=0, until clr.
REQ-028 SHALL return to T0 after the last execute step of every instruction other than halt.
REQ-029 SHALL never assert RAM_read and RAM_write in the same cycle.

Reset
REQ-030 SHALL, when clr=1 at a clock edge, enter T0 from any state, including mid-instruction and HALT.
REQ-031 SHALL hold all outputs at 0 except run=1 in the cycle after reset; T0 outputs are asserted starting in the first cycle with clr=0.
REQ-032 SHALL hold the reset state while clr remains high.

Configuration
REQ-033 SHALL, with MULDIV_EN defined, sequence mul and div (01110, 01111) as:
- E0: Gra, Rout, Yin.
- E1: Grb, Rout, Zin.
- E2: ZLowout, LOin.
- E3: ZHighout, HIin.
REQ-034 SHALL, without MULDIV_EN defined, treat mul and div as nop (REQ-026).

Structure
REQ-035 SHALL place the state enumeration, the opcode localparams, and the bus_src and ld_en bit-index constants in the shared package cpu_pkg.
REQ-036 SHALL split into one sub-module, control_decode: a combinational map from (state, opcode, CON_out) to the output vector; the control_unit top holds only the state register and next-state logic.

Verification
REQ-037 SHALL cover fetch: release clr, opcode=11001 -> T0 asserts bus_src=PCout, MARin, IncPC, Zin; T1 asserts PCin and RAM_read; T2 asserts IRin; the fourth cycle (E0) asserts no outputs.
REQ-038 SHALL cover add: opcode=00011 -> E0 asserts Grb+Yin, E1 asserts Grc+Zin, E2 asserts ZLowout+Gra+R_enable, and the next state is T0 (6 cycles total).
REQ-039 SHALL cover branch: opcode=10010, first with CON_out=0 then with CON_out=1 -> PCin is absent in E3 for the first and present in E3 for the second.
REQ-040 SHALL cover store: opcode=00010 -> E4 asserts RAM_write alone, and RAM_read is never high in the same cycle as RAM_write.
REQ-041 SHALL cover reset mid-instruction: clr=1 during E2 of ld -> the next state is T0, with all outputs 0 while clr is held.
REQ-042 SHALL cover halt: opcode=11010 -> HALT with run=0 held for 20 cycles; clr then returns the FSM to T0 with run=1. A further case checks mul: opcode=01110 produces 4 execute steps when MULDIV_EN is defined and behaves as nop when it is not.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared control-unit definitions: FSM states, opcodes and control-vector layout.
// Build option MULDIV_EN adds the mul/div execute sequence.
package cpu_pkg;

  typedef enum logic [3:0] {T0, T1, T2, E0, E1, E2, E3, E4, HALT} state_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHL  = 5'b01000;
  localparam logic [4:0] OP_ROR  = 5'b01001;
  localparam logic [4:0] OP_ROL  = 5'b01010;
  localparam logic [4:0] OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_ANDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01101;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10011;
  localparam logic [4:0] OP_JAL  = 5'b10100;
  localparam logic [4:0] OP_IN   = 5'b10101;
  localparam logic [4:0] OP_OUT  = 5'b10110;
  localparam logic [4:0] OP_MFHI = 5'b10111;
  localparam logic [4:0] OP_MFLO = 5'b11000;
  localparam logic [4:0] OP_NOP  = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11010;

  // bus_src bit positions
  localparam int BUS_HI  = 0;
  localparam int BUS_LO  = 1;
  localparam int BUS_ZHI = 2;
  localparam int BUS_ZLO = 3;
  localparam int BUS_PC  = 4;
  localparam int BUS_MDR = 5;
  localparam int BUS_IN  = 6;
  localparam int BUS_C   = 7;

  // ld_en bit positions
  localparam int LD_MAR = 0;
  localparam int LD_MDR = 1;
  localparam int LD_IR  = 2;
  localparam int LD_PC  = 3;
  localparam int LD_Y   = 4;
  localparam int LD_Z   = 5;
  localparam int LD_HI  = 6;
  localparam int LD_LO  = 7;
  localparam int LD_CON = 8;
  localparam int LD_IN  = 9;
  localparam int LD_OUT = 10;

  // gsel bit positions
  localparam int G_RC = 0;
  localparam int G_RB = 1;
  localparam int G_RA = 2;

  localparam logic [2:0] MDR_SEL_BUS = 3'b000;
  localparam logic [2:0] MDR_SEL_RAM = 3'b001;

  typedef struct packed {
    logic [2:0]  gsel;
    logic        r_enable;
    logic        rout;
    logic        baout;
    logic [7:0]  bus_src;
    logic [10:0] ld_en;
    logic        ram_read;
    logic        ram_write;
    logic        inc_pc;
    logic [2:0]  mdr_read;
    logic        run;
  } ctrl_t;

  // Number of execute states (E0..) an opcode occupies before returning to T0.
  function automatic logic [2:0] exec_steps(input logic [4:0] op);
    logic [2:0] n;
    n = 3'd1;
    case (op)
      OP_LD, OP_ST:                                    n = 3'd5;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL,
      OP_ROR, OP_ROL, OP_ADDI, OP_ANDI, OP_ORI, OP_LDI: n = 3'd3;
      OP_NEG, OP_NOT, OP_JAL:                          n = 3'd2;
      OP_BR:                                           n = 3'd4;
`ifdef MULDIV_EN
      OP_MUL, OP_DIV:                                  n = 3'd4;
`else
      OP_MUL, OP_DIV:                                  n = 3'd1;
`endif
      OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO,
      OP_NOP, OP_HALT:                                 n = 3'd1;
      default:                                         n = 3'd1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational map from (state, opcode, CON_out) to the full control vector.
// With MULDIV_EN defined, mul/div get their four-step sequence; otherwise they decode as nop.
module control_decode
  import cpu_pkg::*;
(
  input  state_t     state,
  input  logic [4:0] opcode,
  input  logic       con_out,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl     = '0;
    ctrl.run = (state != HALT);
    // The input-port register is loaded from outside the CPU, never by the sequencer.
    ctrl.ld_en[LD_IN] = 1'b0;
    case (state)
      T0: begin
        ctrl.bus_src[BUS_PC] = 1'b1;
        ctrl.ld_en[LD_MAR]   = 1'b1;
        ctrl.inc_pc          = 1'b1;
        ctrl.ld_en[LD_Z]     = 1'b1;
      end
      T1: begin
        ctrl.bus_src[BUS_ZLO] = 1'b1;
        ctrl.ld_en[LD_PC]     = 1'b1;
        ctrl.ram_read         = 1'b1;
        ctrl.mdr_read         = MDR_SEL_RAM;
        ctrl.ld_en[LD_MDR]    = 1'b1;
      end
      T2: begin
        ctrl.bus_src[BUS_MDR] = 1'b1;
        ctrl.ld_en[LD_IR]     = 1'b1;
      end
      E0, E1, E2, E3, E4: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
          OP_ADDI, OP_ANDI, OP_ORI: begin
            case (state)
              E0: begin
                ctrl.gsel[G_RB] = 1'b1;
                ctrl.rout       = 1'b1;
                ctrl.ld_en[LD_Y] = 1'b1;
              end
              E1: begin
                ctrl.ld_en[LD_Z] = 1'b1;
                if (opcode inside {OP_ADDI, OP_ANDI, OP_ORI}) begin
                  ctrl.bus_src[BUS_C] = 1'b1;
                end else begin
                  ctrl.gsel[G_RC] = 1'b1;
                  ctrl.rout       = 1'b1;
                end
              end
              E2: begin
                ctrl.bus_src[BUS_ZLO] = 1'b1;
                ctrl.gsel[G_RA]       = 1'b1;
                ctrl.r_enable         = 1'b1;
              end
              default: ;
            endcase
          end
`ifdef MULDIV_EN
          OP_MUL, OP_DIV: begin
            case (state)
              E0: begin
                ctrl.gsel[G_RA]  = 1'b1;
                ctrl.rout        = 1'b1;
                ctrl.ld_en[LD_Y] = 1'b1;
              end
              E1: begin
                ctrl.gsel[G_RB]  = 1'b1;
                ctrl.rout        = 1'b1;
                ctrl.ld_en[LD_Z] = 1'b1;
              end
              E2: begin
                ctrl.bus_src[BUS_ZLO] = 1'b1;
                ctrl.ld_en[LD_LO]     = 1'b1;
              end
              E3: begin
                ctrl.bus_src[BUS_ZHI] = 1'b1;
                ctrl.ld_en[LD_HI]     = 1'b1;
              end
              default: ;
            endcase
          end
`endif
          OP_NEG, OP_NOT: begin
            case (state)
              E0: begin
                ctrl.gsel[G_RB]  = 1'b1;
                ctrl.rout        = 1'b1;
                ctrl.ld_en[LD_Z] = 1'b1;
              end
              E1: begin
                ctrl.bus_src[BUS_ZLO] = 1'b1;
                ctrl.gsel[G_RA]       = 1'b1;
                ctrl.r_enable         = 1'b1;
              end
              default: ;
            endcase
          end
          OP_LD, OP_LDI, OP_ST: begin
            // Effective address = base register (R0 reads as zero via BAout) + C.
            case (state)
              E0: begin
                ctrl.gsel[G_RB]  = 1'b1;
                ctrl.baout       = 1'b1;
                ctrl.ld_en[LD_Y] = 1'b1;
              end
              E1: begin
                ctrl.bus_src[BUS_C] = 1'b1;
                ctrl.ld_en[LD_Z]    = 1'b1;
              end
              E2: begin
                ctrl.bus_src[BUS_ZLO] = 1'b1;
                if (opcode == OP_LDI) begin
                  ctrl.gsel[G_RA] = 1'b1;
                  ctrl.r_enable   = 1'b1;
                end else begin
                  ctrl.ld_en[LD_MAR] = 1'b1;
                end
              end
              E3: begin
                ctrl.ld_en[LD_MDR] = 1'b1;
                if (opcode == OP_ST) begin
                  ctrl.gsel[G_RA] = 1'b1;
                  ctrl.rout       = 1'b1;
                  ctrl.mdr_read   = MDR_SEL_BUS;
                end else begin
                  ctrl.ram_read = 1'b1;
                  ctrl.mdr_read = MDR_SEL_RAM;
                end
              end
              E4: begin
                if (opcode == OP_ST) begin
                  ctrl.ram_write = 1'b1;
                end else begin
                  ctrl.bus_src[BUS_MDR] = 1'b1;
                  ctrl.gsel[G_RA]       = 1'b1;
                  ctrl.r_enable         = 1'b1;
                end
              end
              default: ;
            endcase
          end
          OP_BR: begin
            case (state)
              E0: begin
                ctrl.gsel[G_RA]    = 1'b1;
                ctrl.rout          = 1'b1;
                ctrl.ld_en[LD_CON] = 1'b1;
              end
              E1: begin
                ctrl.bus_src[BUS_PC] = 1'b1;
                ctrl.ld_en[LD_Y]     = 1'b1;
              end
              E2: begin
                ctrl.bus_src[BUS_C] = 1'b1;
                ctrl.ld_en[LD_Z]    = 1'b1;
              end
              E3: begin
                ctrl.bus_src[BUS_ZLO] = con_out;
                ctrl.ld_en[LD_PC]     = con_out;
              end
              default: ;
            endcase
          end
          OP_JR: begin
            if (state == E0) begin
              ctrl.gsel[G_RA]   = 1'b1;
              ctrl.rout         = 1'b1;
              ctrl.ld_en[LD_PC] = 1'b1;
            end
          end
          OP_JAL: begin
            // Link register R15 is addressed through the Grb field.
            case (state)
              E0: begin
                ctrl.bus_src[BUS_PC] = 1'b1;
                ctrl.gsel[G_RB]      = 1'b1;
                ctrl.r_enable        = 1'b1;
              end
              E1: begin
                ctrl.gsel[G_RA]   = 1'b1;
                ctrl.rout         = 1'b1;
                ctrl.ld_en[LD_PC] = 1'b1;
              end
              default: ;
            endcase
          end
          OP_IN, OP_MFHI, OP_MFLO: begin
            if (state == E0) begin
              ctrl.bus_src[BUS_IN] = (opcode == OP_IN);
              ctrl.bus_src[BUS_HI] = (opcode == OP_MFHI);
              ctrl.bus_src[BUS_LO] = (opcode == OP_MFLO);
              ctrl.gsel[G_RA]      = 1'b1;
              ctrl.r_enable        = 1'b1;
            end
          end
          OP_OUT: begin
            if (state == E0) begin
              ctrl.gsel[G_RA]    = 1'b1;
              ctrl.rout          = 1'b1;
              ctrl.ld_en[LD_OUT] = 1'b1;
            end
          end
          OP_NOP, OP_HALT: ;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Moore sequencer for the CPU: state register, next-state logic and the decode instance.
// Build option MULDIV_EN (handled in cpu_pkg/control_decode) enables mul/div sequencing.
module control_unit
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic [4:0]  opcode,
  input  logic        CON_out,
  output logic [2:0]  gsel,
  output logic        R_enable,
  output logic        Rout,
  output logic        BAout,
  output logic [7:0]  bus_src,
  output logic [10:0] ld_en,
  output logic        RAM_read,
  output logic        RAM_write,
  output logic        IncPC,
  output logic [2:0]  MDR_read,
  output logic        run
);

  state_t     state;
  state_t     state_next;
  logic       hold;
  logic [4:0] op_q;
  logic [4:0] op_cur;
  logic [2:0] steps;
  ctrl_t      dec;
  ctrl_t      ctrl;

  // IR is valid from E0 on; later execute steps use the copy captured in E0.
  assign op_cur = (state == E0) ? opcode : op_q;
  assign steps  = exec_steps(op_cur);

  always_comb begin
    state_next = state;
    case (state)
      T0:      state_next = T1;
      T1:      state_next = T2;
      T2:      state_next = E0;
      E0: begin
        if (op_cur == OP_HALT)   state_next = HALT;
        else if (steps > 3'd1)   state_next = E1;
        else                     state_next = T0;
      end
      E1:      state_next = (steps > 3'd2) ? E2 : T0;
      E2:      state_next = (steps > 3'd3) ? E3 : T0;
      E3:      state_next = (steps > 3'd4) ? E4 : T0;
      E4:      state_next = T0;
      HALT:    state_next = HALT;
      default: state_next = T0;
    endcase
  end

  // hold marks the idle reset cycle(s): state sits at T0 with outputs quiet
  // until clr has been sampled low once.
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= T0;
      hold  <= 1'b1;
    end else begin
      hold <= 1'b0;
      if (!hold) state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (state == E0) op_q <= opcode;
  end

  control_decode u_decode (
    .state   (state),
    .opcode  (op_cur),
    .con_out (CON_out),
    .ctrl    (dec)
  );

  always_comb begin
    ctrl = dec;
    if (hold) begin
      ctrl     = '0;
      ctrl.run = 1'b1;
    end
  end

  assign gsel      = ctrl.gsel;
  assign R_enable  = ctrl.r_enable;
  assign Rout      = ctrl.rout;
  assign BAout     = ctrl.baout;
  assign bus_src   = ctrl.bus_src;
  assign ld_en     = ctrl.ld_en;
  assign RAM_read  = ctrl.ram_read;
  assign RAM_write = ctrl.ram_write;
  assign IncPC     = ctrl.inc_pc;
  assign MDR_read  = ctrl.mdr_read;
  assign run       = ctrl.run;

endmodule
